mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers,
//  sitting in EX beside the ALU. It is the responder end of the EX start/busy
//  handshake: the pipeline initiates an op, and the unit runs iteratively.
//  Hazard logic stalls on busy; MFHI/MFLO read hi/lo directly.
// PARAMETERS
//  WIDTH  32  operand width; iteration count = WIDTH
// PORTS
//  clk    in   1      rising-edge clock
//  reset  in   1      asynchronous, active-low; clears all state
//  start  in   1      request; sampled only when busy==0
//  op     in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 ignored
//  in1    in   WIDTH  rs operand (multiplicand/dividend, MTHI/MTLO source)
//  in2    in   WIDTH  rt operand (multiplier/divisor)
//  flush  in   1      abort in-flight op (branch squash/exception)
//  busy   out  1      op in progress; pipeline must stall MFHI/MFLO/new ops
//  done   out  1      one-cycle pulse on the cycle hi/lo take a mul/div result
//  hi     out  WIDTH  HI register (product high / remainder)
//  lo     out  WIDTH  LO register (product low / quotient)
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
//  FSM states IDLE, RUN, FIX:
//   IDLE: start&&op in 0..3 at edge E0 -> RUN; latch |operands| (signed ops)
//     plus result-sign flags; counter=WIDTH; busy=1 from E0.
//     start&&op==4: hi<=in1 at E0; op==5: lo<=in1 at E0; no busy, no done.
//     start&&op in 6..7: no effect.
//   RUN: one iteration per cycle; counter decrements; at counter==1 -> FIX.
//     MUL: shift-add on 2*WIDTH accumulator. DIV: restoring, 1 quotient bit/cycle.
//   FIX: apply sign correction; write hi/lo at edge E0+WIDTH+1; done=1
//     and busy=0 for that cycle; -> IDLE.
//  Latency: result visible in hi/lo exactly WIDTH+1 cycles after the start edge.
//  Arithmetic rules:
//   MULT/MULTU: {hi,lo} = full 2*WIDTH product, signed/unsigned.
//   DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
//   DIVU: unsigned quotient/remainder.
//   Divide by zero (any sign): lo=all ones, hi=in1, after full latency.
//   DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
//  Boundaries:
//   start while busy: ignored, and not queued.
//   flush while busy: next edge -> IDLE, busy=0, done=0, hi/lo unchanged.
//   flush && start in IDLE on the same cycle: flush wins; nothing is accepted,
//     including MTHI/MTLO.
//   flush in FIX cycle: result is discarded, hi/lo unchanged.
//   reset mid-op: immediate IDLE; hi/lo cleared.
//   hi/lo hold their values at all other times; they never change mid-RUN.
// TESTING
//  1 reset=0 mid-RUN -> busy=0, done=0, hi=0, lo=0 immediately, without a clock edge.
//  2 MULT in1=0xFFFFFFFE(-2), in2=0x00000003 -> after 33 cycles hi=0xFFFFFFFF,
//    lo=0xFFFFFFFA, done pulses 1 cycle; MULTU same operands -> hi=0x2, lo=0xFFFFFFFA.
//  3 DIV in1=0xFFFFFFF9(-7), in2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
//  4 DIV by 0 with in1=0x1234 -> lo=0xFFFFFFFF, hi=0x1234;
//    DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  5 MULT started, flush at cycle 10 -> busy drops next edge, done never
//    pulses, hi/lo keep prior values; a second start during busy is ignored.
//  6 MTHI in1=0xA5A5A5A5, next cycle MTLO in1=0x5A5A5A5A -> hi/lo updated
//    1 edge each, busy stays 0; MTLO with flush=1 -> lo unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div, neg_q, neg_r, dz;

  logic               accept, mt_hi, mt_lo, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH-1:0]   rem_nx;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_nx, div_nx, prod;
  logic [WIDTH-1:0]   quo, rem;

  assign accept    = (state == IDLE) && start && !flush && !op[2];
  assign mt_hi     = (state == IDLE) && start && !flush && (op == 3'd4);
  assign mt_lo     = (state == IDLE) && start && !flush && (op == 3'd5);
  assign is_signed = !op[0];
  assign a_neg     = is_signed && in1[WIDTH-1];
  assign b_neg     = is_signed && in2[WIDTH-1];
  assign a_abs     = a_neg ? -in1 : in1;
  assign b_abs     = b_neg ? -in2 : in2;
  assign busy      = (state != IDLE);

  // Multiply: multiplier sits in acc low half and shifts out as the product shifts in.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
  assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide: remainder in acc high half, dividend/quotient in low half.
  assign rem_sh = acc[2*WIDTH-1:WIDTH-1];
  assign div_ge = (rem_sh >= {1'b0, dvs});
  assign rem_nx = div_ge ? (rem_sh[WIDTH-1:0] - dvs) : rem_sh[WIDTH-1:0];
  assign div_nx = {rem_nx, acc[WIDTH-2:0], div_ge};

  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = RUN;
      RUN: begin
        if (flush)                  state_nx = IDLE;
        else if (cnt == CW'(1))     state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      dvs    <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nx;
      done  <= (state == FIX) && !flush;
      if (accept) begin
        cnt    <= CW'(WIDTH);
        is_div <= op[1];
        acc    <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
        dvs    <= op[1] ? b_abs : a_abs;
        a_raw  <= in1;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        dz     <= op[1] && (in2 == '0);
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
        acc <= is_div ? div_nx : mul_nx;
      end
      if (mt_hi) hi <= in1;
      if (mt_lo) lo <= in1;
      // Divide by zero reports the raw dividend in HI regardless of sign.
      if ((state == FIX) && !flush) begin
        if (!is_div) begin
          {hi, lo} <= prod;
        end else if (dz) begin
          hi <= a_raw;
          lo <= '1;
        end else begin
          hi <= rem;
          lo <= quo;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else chk("result_hilo", {hi, lo}, sb.pop_front());
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    @(negedge clk);
    op = o; in1 = a; in2 = b; start = 1'b1;
    sb.push_back({eh, el});
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'd33);
    @(negedge clk);
    chk("done_one_cycle", {62'd0, done, busy}, 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] ra, rb;
    longint sp;
    bit busy_seen;

    vecs = '{
      '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA},
      '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA},
      '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
      '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003},
      '{3'd2, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF},
      '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
      '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
      '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
      '{3'd3, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF},
      '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
      '{3'd3, 32'h80000000, 32'h00000003, 32'h00000002, 32'h2AAAAAAA},
      '{3'd0, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988},
      '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF}
    };

    #1;
    chk("reset_state", {30'd0, busy, done, hi, lo} , 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      sp = longint'($signed(ra)) * longint'($signed(rb));
      run_op(3'd0, ra, rb, sp[63:32], sp[31:0]);
      rb = $urandom_range(1, 32'hFFFF);
      run_op(3'd3, ra, rb, ra % rb, ra / rb);
    end

    // MTHI / MTLO, then MTLO squashed by flush, then ignored op 6
    @(negedge clk);
    op = 3'd4; in1 = 32'hA5A5A5A5; start = 1'b1;
    @(negedge clk);
    chk("mthi_hi", {32'd0, hi}, {32'd0, 32'hA5A5A5A5});
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    op = 3'd5; in1 = 32'h5A5A5A5A;
    @(negedge clk);
    chk("mtlo_hilo", {hi, lo}, 64'hA5A5A5A5_5A5A5A5A);
    chk("mtlo_busy", {63'd0, busy}, 64'd0);
    in1 = 32'h11111111; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; op = 3'd6;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_flush_op6", {hi, lo}, 64'hA5A5A5A5_5A5A5A5A);
    chk("op6_busy", {63'd0, busy}, 64'd0);

    // flush mid-RUN with a second start held during busy
    op = 3'd0; in1 = 32'd5; in2 = 32'd7; start = 1'b1;
    @(negedge clk);
    op = 3'd3;
    repeat (9) @(negedge clk);
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    busy_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    chk("start_not_queued", {63'd0, busy_seen}, 64'd0);
    chk("flush_hilo", {hi, lo}, 64'hA5A5A5A5_5A5A5A5A);

    // flush in FIX cycle discards the result
    @(negedge clk);
    op = 3'd1; in1 = 32'd5; in2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    chk("fix_busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fix_flush_state", {62'd0, done, busy}, 64'd0);
    repeat (3) @(negedge clk);
    chk("fix_flush_hilo", {hi, lo}, 64'hA5A5A5A5_5A5A5A5A);

    // async reset mid-RUN
    op = 3'd2; in1 = 32'd100; in2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrun_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    chk("async_reset", {30'd0, busy, done, hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_idle", {30'd0, busy, done, hi, lo}, 64'd0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
